// File: rtl/tff_mod_counter_pkg.sv
// Shared definitions for the T-cell modulo-N counter.
//   DIR_UP / DIR_DOWN : count-direction encodings for the dir input
//   MAX_W             : widest counter the helper supports
//   calc_toggle()     : per-bit toggle vector for a given q, width, modulus
//                       and direction, before enable/load gating
package tff_mod_counter_pkg;

  localparam int   MAX_W    = 16;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Up: bit i toggles when all lower bits are 1; at MODULUS-1 toggle every
  // set bit so q lands on 0.
  // Down: bit i toggles when all lower bits are 0; at 0 toggle into MODULUS-1.
  function automatic logic [MAX_W-1:0] calc_toggle(
    input logic [MAX_W-1:0] q,
    input int               width,
    input int               modulus,
    input logic             dir
  );
    logic [MAX_W-1:0] t;
    logic             run;
    t   = '0;
    run = 1'b1;
    if (dir == DIR_UP) begin
      if (int'(q) == modulus - 1) begin
        t = q;
      end else begin
        for (int i = 0; i < MAX_W; i++) begin
          if (i < width) begin
            t[i] = run;
            run  = run & q[i];
          end
        end
      end
    end else begin
      if (q == '0) begin
        t = MAX_W'(modulus - 1);
      end else begin
        for (int i = 0; i < MAX_W; i++) begin
          if (i < width) begin
            t[i] = run;
            run  = run & ~q[i];
          end
        end
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/tff_mod_counter_cell.sv
// One-bit T storage cell, falling-edge update, async active-low reset.
//   clk   : clock (state changes on negedge)
//   rst_n : async active-low reset, clears q
//   t     : toggle request
//   q     : stored bit
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)  q <= 1'b0;
    else if (t)  q <= ~q;
  end

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-N counter built from WIDTH T cells; next q = q ^ toggle.
//   clk      : clock, all state updates on falling edge
//   rst_n    : async active-low reset (q, load_err -> 0)
//   dir      : 1 = up, 0 = down (only with TFF_MOD_COUNTER_UPDOWN_EN)
//   en       : count enable
//   load     : synchronous parallel load, wins over en
//   load_val : value to load; >= MODULUS loads 0 and flags load_err
//   q        : registered count
//   t_out    : toggle vector applied at next falling edge (0 if !en or load)
//   tc       : terminal count for cascading
//   load_err : one-cycle registered pulse after an illegal load
// Optional feature macro: TFF_MOD_COUNTER_UPDOWN_EN adds dir and down counting.
module tff_mod_counter
  import tff_mod_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef TFF_MOD_COUNTER_UPDOWN_EN
  input  logic             dir,
`endif
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_out,
  output logic             tc,
  output logic             load_err
);

  if (WIDTH < 1 || WIDTH > MAX_W) begin : g_bad_width
    $error("tff_mod_counter: WIDTH out of range 1..16");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_mod
    $error("tff_mod_counter: MODULUS out of range 2..2^WIDTH");
  end

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic             dir_i;
  logic             active;
  logic             legal;
  logic [WIDTH-1:0] load_tgt;
  logic [WIDTH-1:0] cell_t;
  logic [MAX_W-1:0] tog_full;
  logic             unused_tog;

`ifdef TFF_MOD_COUNTER_UPDOWN_EN
  assign dir_i = dir;
  assign tc    = active & ((dir_i == DIR_UP) ? (q == LAST) : (q == '0));
`else
  assign dir_i = DIR_UP;
  assign tc    = active & (q == LAST);
`endif

  assign active     = en & ~load;
  assign tog_full   = calc_toggle(MAX_W'(q), WIDTH, MODULUS, dir_i);
  assign unused_tog = ^tog_full;
  assign t_out      = active ? tog_full[WIDTH-1:0] : '0;

  // Loads go through the T cells too: toggle exactly the bits that differ.
  // t_out stays 0 during a load so external toggle stages hold.
  assign legal    = int'(load_val) < MODULUS;
  assign load_tgt = legal ? load_val : '0;
  assign cell_t   = load ? (q ^ load_tgt) : t_out;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (cell_t[i]),
      .q     (q[i])
    );
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) load_err <= 1'b0;
    else        load_err <= load & ~legal;
  end

endmodule
